// File: rtl/area_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : area_classifier
//  Description : Averages per-frame dark-pixel area over 2^AVG_LOG2 frames,
//                bins the average into four size classes and commits a class
//                once STABLE_N consecutive windows agree.
//  Revision    : 1.0 - initial release
// ============================================================================
module area_classifier #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned STABLE_N = 2,
    parameter logic [23:0] T_EMPTY  = 24'd2000,
    parameter logic [23:0] T_SMALL  = 24'd20000,
    parameter logic [23:0] T_MID    = 24'd60000
) (
    input  logic        pixelclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        i_vs,
    input  logic [23:0] i_area,
    output logic [23:0] o_area_avg,
    output logic        o_win,
    output logic [1:0]  o_class,
    output logic        o_valid,
    output logic        o_stable
);

    localparam int unsigned c_sum_w  = 24 + AVG_LOG2;
    localparam logic [3:0]  c_stable = 4'(STABLE_N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_vs;
    logic                  r_smp_stb;
    logic [c_sum_w-1:0]    r_sum;
    logic [AVG_LOG2-1:0]   r_cnt;
    logic [3:0]            r_agree;
    logic [1:0]            r_prev_cand;
    logic                  r_committed;

    logic [23:0]           w_avg;
    logic [1:0]            w_cand;
    logic [3:0]            w_agree_nxt;
    logic                  w_agree_ok;
    logic                  w_commit;
    logic                  w_clear;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge pixelclk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic; dropping en returns to IDLE from anywhere
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_SYNC;
                ST_SYNC:   if (r_smp_stb) w_state_nxt = ST_ACCUM;
                ST_ACCUM:  if (r_smp_stb && (r_cnt == '1)) w_state_nxt = ST_DECIDE;
                ST_DECIDE: w_state_nxt = ST_ACCUM;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Window decision: average, classify, update agreement
    // ------------------------------------------------------------------------
    always_comb begin
        w_avg = 24'(r_sum >> AVG_LOG2);

        if (w_avg < T_EMPTY) begin
            w_cand = 2'd0;
        end else if (w_avg < T_SMALL) begin
            w_cand = 2'd1;
        end else if (w_avg < T_MID) begin
            w_cand = 2'd2;
        end else begin
            w_cand = 2'd3;
        end

        if (w_cand == r_prev_cand) begin
            w_agree_nxt = (r_agree >= c_stable) ? c_stable : (r_agree + 4'd1);
        end else begin
            w_agree_nxt = 4'd1;
        end

        w_agree_ok = (w_agree_nxt >= c_stable);
        // A repeated class is only re-announced after a fresh start
        w_commit   = w_agree_ok && (!r_committed || (w_cand != o_class));
        w_clear    = !en || (r_state == ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Datapath and outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge pixelclk) begin
        if (!rst_n) begin
            r_vs        <= 1'b0;
            r_smp_stb   <= 1'b0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_agree     <= 4'd0;
            r_prev_cand <= 2'd0;
            r_committed <= 1'b0;
            o_area_avg  <= 24'd0;
            o_win       <= 1'b0;
            o_class     <= 2'd0;
            o_valid     <= 1'b0;
            o_stable    <= 1'b0;
        end else begin
            r_vs      <= i_vs;
            // Delay one edge so the counter's latched area is settled
            r_smp_stb <= r_vs & ~i_vs;
            o_win     <= 1'b0;
            o_valid   <= 1'b0;

            if (w_clear) begin
                r_sum       <= '0;
                r_cnt       <= '0;
                r_agree     <= 4'd0;
                r_prev_cand <= 2'd0;
                r_committed <= 1'b0;
                o_stable    <= 1'b0;
            end else if ((r_state == ST_ACCUM) && r_smp_stb) begin
                r_sum <= r_sum + c_sum_w'(i_area);
                r_cnt <= r_cnt + AVG_LOG2'(1);
            end else if (r_state == ST_DECIDE) begin
                o_area_avg <= w_avg;
                o_win      <= 1'b1;
                r_agree    <= w_agree_nxt;
                if (w_cand != r_prev_cand) begin
                    r_prev_cand <= w_cand;
                end
                if (w_commit) begin
                    o_class     <= w_cand;
                    o_valid     <= 1'b1;
                    r_committed <= 1'b1;
                end
                o_stable <= w_agree_ok;
                r_sum    <= '0;
                r_cnt    <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_area_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_area_classifier
//  Description : Directed self-checking bench for area_classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_area_classifier;

    logic        pixelclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        i_vs     = 1'b0;
    logic [23:0] i_area   = 24'd0;
    logic [23:0] o_area_avg;
    logic        o_win;
    logic [1:0]  o_class;
    logic        o_valid;
    logic        o_stable;

    int n_cmp = 0;
    int n_err = 0;
    int nw;
    int nv;
    int ns;
    int a3[4] = '{1000, 1000, 3000, 3000};

    always #5 pixelclk = ~pixelclk;

    area_classifier dut (
        .pixelclk   (pixelclk),
        .rst_n      (rst_n),
        .en         (en),
        .i_vs       (i_vs),
        .i_area     (i_area),
        .o_area_avg (o_area_avg),
        .o_win      (o_win),
        .o_class    (o_class),
        .o_valid    (o_valid),
        .o_stable   (o_stable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixelclk);
        #1;
    endtask

    // Returns two edges after the falling-vsync edge: a window's results are visible then
    task automatic frame(input int area);
        i_area = 24'(area);
        i_vs   = 1'b1;
        repeat (3) tick();
        i_vs   = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_avg",    32'(o_area_avg), 0);
        check("rst_win",    32'(o_win),      0);
        check("rst_class",  32'(o_class),    0);
        check("rst_valid",  32'(o_valid),    0);
        check("rst_stable", 32'(o_stable),   0);

        // Steady 30000: first frame discarded, commit class 2 after two windows
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        frame(30000);
        for (int i = 1; i <= 8; i++) begin
            frame(30000);
            check($sformatf("s1_win_f%0d", i),   32'(o_win),   (i == 4 || i == 8) ? 1 : 0);
            check($sformatf("s1_valid_f%0d", i), 32'(o_valid), (i == 8) ? 1 : 0);
            if (i == 4) begin
                check("s1_avg_w1",    32'(o_area_avg), 30000);
                check("s1_stable_w1", 32'(o_stable),   0);
                check("s1_class_w1",  32'(o_class),    0);
            end
        end
        check("s1_class",  32'(o_class),    2);
        check("s1_stable", 32'(o_stable),   1);
        check("s1_avg",    32'(o_area_avg), 30000);
        tick();
        check("s1_win_width",   32'(o_win),   0);
        check("s1_valid_width", 32'(o_valid), 0);

        // Same class again: windows complete but nothing is re-committed
        nw = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            frame(30000);
            nw += int'(o_win);
            nv += int'(o_valid);
        end
        check("s2_nwin",   nw, 2);
        check("s2_nvalid", nv, 0);
        check("s2_class",  32'(o_class),  2);
        check("s2_stable", 32'(o_stable), 1);

        // Average exactly on T_EMPTY lands in class 1
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) frame(a3[k]);
            check($sformatf("s3_win_w%0d", w),   32'(o_win),      1);
            check($sformatf("s3_avg_w%0d", w),   32'(o_area_avg), 2000);
            check($sformatf("s3_valid_w%0d", w), 32'(o_valid),    (w == 1) ? 1 : 0);
            check($sformatf("s3_class_w%0d", w), 32'(o_class),    (w == 1) ? 1 : 2);
        end

        // Alternating classes never reach agreement
        nv = 0;
        ns = 0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) begin
                frame((w % 2 == 1) ? 10000 : 70000);
                nv += int'(o_valid);
            end
            check($sformatf("s4_win_w%0d", w), 32'(o_win), 1);
            ns += int'(o_stable);
        end
        check("s4_nvalid",  nv, 0);
        check("s4_nstable", ns, 0);
        check("s4_class",   32'(o_class),    1);
        check("s4_avg",     32'(o_area_avg), 10000);

        // Enable dropped mid-window: partial sum and agreement discarded
        frame(4000);
        frame(4000);
        check("s5_win_partial", 32'(o_win), 0);
        en = 1'b0;
        repeat (4) tick();
        check("s5_class_hold", 32'(o_class),    1);
        check("s5_avg_hold",   32'(o_area_avg), 10000);
        en = 1'b1;
        tick();
        frame(70000);
        for (int i = 1; i <= 8; i++) begin
            frame(70000);
            check($sformatf("s5_win_f%0d", i),   32'(o_win),   (i == 4 || i == 8) ? 1 : 0);
            check($sformatf("s5_valid_f%0d", i), 32'(o_valid), (i == 8) ? 1 : 0);
            if (i == 4) begin
                check("s5_avg_w1",   32'(o_area_avg), 70000);
                check("s5_class_w1", 32'(o_class),    1);
            end
        end
        check("s5_class",  32'(o_class),  3);
        check("s5_stable", 32'(o_stable), 1);

        // One-cycle reset mid-window, then the first scenario again
        frame(5000);
        frame(5000);
        rst_n = 1'b0;
        tick();
        check("s6_rst_avg",    32'(o_area_avg), 0);
        check("s6_rst_win",    32'(o_win),      0);
        check("s6_rst_class",  32'(o_class),    0);
        check("s6_rst_valid",  32'(o_valid),    0);
        check("s6_rst_stable", 32'(o_stable),   0);
        rst_n = 1'b1;
        tick();
        frame(30000);
        for (int i = 1; i <= 8; i++) begin
            frame(30000);
            check($sformatf("s6_win_f%0d", i),   32'(o_win),   (i == 4 || i == 8) ? 1 : 0);
            check($sformatf("s6_valid_f%0d", i), 32'(o_valid), (i == 8) ? 1 : 0);
        end
        check("s6_class",  32'(o_class),    2);
        check("s6_stable", 32'(o_stable),   1);
        check("s6_avg",    32'(o_area_avg), 30000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
